load_store_unit: RTL and testbench



---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_align.sv | 54 +++++
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-decode helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int LANE_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_illegal(input logic write, input logic [2:0] funct3);
    if (write) begin
      return funct3 > 3'd2;
    end else begin
      return (funct3 == 3'd3) || (funct3 > 3'd5);
    end
  endfunction

  function automatic logic is_span(input logic [1:0] offset, input logic [2:0] funct3);
    return ({1'b0, offset} + access_bytes(funct3)) > 3'd4;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] offset, input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return offset[0];
      default: return offset != 2'd0;
    endcase
  endfunction

  function automatic logic [5:0] lane_shift(input logic [1:0] offset);
    return 6'(offset) * 6'(LANE_W);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension and store lane merge over a {hi,lo} word pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_lo,
  output logic [31:0] merged_hi
);

  logic [5:0]  shamt_s;
  logic [63:0] pair_s;
  logic [63:0] shifted_s;
  logic [63:0] base_mask_s;
  logic [63:0] mask_s;
  logic [63:0] merged_s;

  assign shamt_s   = lane_shift(offset);
  assign pair_s    = {hi_word, lo_word};
  assign shifted_s = pair_s >> shamt_s;

  // Lane mask of the access size, before positioning at the offset
  always_comb begin
    base_mask_s = 64'h0;
    case (funct3[1:0])
      2'b00:   base_mask_s = 64'h0000_0000_0000_00FF;
      2'b01:   base_mask_s = 64'h0000_0000_0000_FFFF;
      default: base_mask_s = 64'h0000_0000_FFFF_FFFF;
    endcase
  end

  assign mask_s    = base_mask_s << shamt_s;
  assign merged_s  = (pair_s & ~mask_s) | ((64'(wdata) << shamt_s) & mask_s);
  assign merged_lo = merged_s[31:0];
  assign merged_hi = merged_s[63:32];

  // Truncate to size and extend according to funct3
  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_H:    load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_W:    load_data = shifted_s[31:0];
      F3_BU:   load_data = {24'h0, shifted_s[7:0]};
      F3_HU:   load_data = {16'h0, shifted_s[15:0]};
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: word RAM access with read-modify-write sub-word stores.
// Build option LSU_MISALIGNED_SPLIT_EN splits word-spanning accesses into two word accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_t state_r, state_s;

  logic              write_r;
  logic [2:0]        funct3_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] lo_word_r;
  logic [DATA_W-1:0] hi_word_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic              req_bad_s;
  logic              split_s;
  logic              rsp_set_s;
  logic [DATA_W-1:0] rsp_data_s;
  logic              rsp_flag_s;
  logic [DATA_W-1:0] lo_src_s;
  logic [DATA_W-1:0] hi_src_s;
  logic [DATA_W-1:0] load_data_s;
  logic [DATA_W-1:0] merged_lo_s;
  logic [DATA_W-1:0] merged_hi_s;
  logic [ADDR_W-3:0] lo_idx_s;
  logic [ADDR_W-3:0] hi_idx_s;

  assign accept_s = req_valid && (state_r == IDLE);
  assign lo_idx_s = addr_r[ADDR_W-1:2];
  assign hi_idx_s = lo_idx_s + (ADDR_W-2)'(1);

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign req_bad_s = is_illegal(req_write, req_funct3);
  assign split_s   = is_span(addr_r[1:0], funct3_r);
`else
  assign req_bad_s = is_illegal(req_write, req_funct3) || is_misaligned(req_addr[1:0], req_funct3);
  assign split_s   = 1'b0;
`endif

  // The word being read this cycle comes straight from the RAM; the other from its capture register
  always_comb begin
    lo_src_s = lo_word_r;
    hi_src_s = hi_word_r;
    if (state_r == RD_LO) begin
      lo_src_s = mem_rdata;
    end else if (state_r == RD_HI) begin
      hi_src_s = mem_rdata;
    end else begin
      lo_src_s = lo_word_r;
    end
  end

  lsu_align u_align (
    .offset    (addr_r[1:0]),
    .funct3    (funct3_r),
    .lo_word   (lo_src_s),
    .hi_word   (hi_src_s),
    .wdata     (wdata_r),
    .load_data (load_data_s),
    .merged_lo (merged_lo_s),
    .merged_hi (merged_hi_s)
  );

  // Next-state, RAM-side outputs and response capture decode
  always_comb begin
    state_s    = state_r;
    rsp_set_s  = 1'b0;
    rsp_data_s = '0;
    rsp_flag_s = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          state_s = IDLE;
        end else if (req_bad_s) begin
          state_s    = RESP;
          rsp_set_s  = 1'b1;
          rsp_flag_s = 1'b1;
        end else if (req_write && (req_funct3 == F3_W) && (req_addr[1:0] == 2'b00)) begin
          state_s = WR_LO;
        end else begin
          state_s = RD_LO;
        end
      end
      RD_LO: begin
        mem_addr = {lo_idx_s, 2'b00};
        if (split_s) begin
          state_s = RD_HI;
        end else if (write_r) begin
          state_s = WR_LO;
        end else begin
          state_s    = RESP;
          rsp_set_s  = 1'b1;
          rsp_data_s = load_data_s;
        end
      end
      RD_HI: begin
        mem_addr = {hi_idx_s, 2'b00};
        if (write_r) begin
          state_s = WR_LO;
        end else begin
          state_s    = RESP;
          rsp_set_s  = 1'b1;
          rsp_data_s = load_data_s;
        end
      end
      WR_LO: begin
        mem_addr  = {lo_idx_s, 2'b00};
        mem_wdata = merged_lo_s;
        mem_we    = 1'b1;
        if (split_s) begin
          state_s = WR_HI;
        end else begin
          state_s   = RESP;
          rsp_set_s = 1'b1;
        end
      end
      WR_HI: begin
        mem_addr  = {hi_idx_s, 2'b00};
        mem_wdata = merged_hi_s;
        mem_we    = 1'b1;
        state_s   = RESP;
        rsp_set_s = 1'b1;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, request latch, read-word capture and held response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      write_r     <= 1'b0;
      funct3_r    <= 3'd0;
      addr_r      <= '0;
      wdata_r     <= '0;
      lo_word_r   <= '0;
      hi_word_r   <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        write_r  <= req_write;
        funct3_r <= req_funct3;
        addr_r   <= req_addr;
        wdata_r  <= req_wdata;
      end
      if (state_r == RD_LO) begin
        lo_word_r <= mem_rdata;
      end
      if (state_r == RD_HI) begin
        hi_word_r <= mem_rdata;
      end
      if (rsp_set_s) begin
        rsp_rdata_r <= rsp_data_s;
        rsp_err_r   <= rsp_flag_s;
      end
    end
  end

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = (state_r == RESP);
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, reset corner case and random accesses
// against a byte-level reference model; honours LSU_MISALIGNED_SPLIT_EN.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:255];
  logic [31:0] shadow [0:255];
  logic        preload_en = 1'b0;
  logic [7:0]  preload_idx = 8'd0;
  logic [31:0] preload_val = 32'h0;

  int errors = 0;
  int checks = 0;

  logic [31:0] got_rd;
  logic        got_err;
  int          got_lat;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clock = ~clock;

  // Zero-delay word RAM; words 0 and 1 ignore unit writes
  assign mem_rdata = ram[mem_addr[9:2]];
  always @(posedge clock) begin
    if (preload_en) ram[preload_idx] <= preload_val;
    else if (mem_we && (mem_addr[9:2] > 8'd1)) ram[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clock);
    preload_en  = 1'b1;
    preload_idx = 8'(idx);
    preload_val = val;
    @(posedge clock);
    #1 preload_en = 1'b0;
    shadow[idx] = val;
  endtask

  // Reference model: byte-addressed view of the shadow RAM
  function automatic logic [7:0] get_byte(input logic [31:0] a);
    logic [31:0] w;
    w = shadow[int'(a[9:2])];
    return 8'(w >> (8 * int'(a[1:0])));
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
    int idx;
    int sh;
    idx = int'(a[9:2]);
    sh  = 8 * int'(a[1:0]);
    if (idx >= 2) shadow[idx] = (shadow[idx] & ~(32'hFF << sh)) | ({24'h0, b} << sh);
  endtask

  task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic err, output int lat, output int nwr);
    int sz;
    int o;
    bit span;
    bit illegal;
    bit misal;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    o = int'(addr[1:0]);
    span = (o + sz) > 4;
    illegal = wr ? (f3 >= 3'd3) : ((f3 == 3'd3) || (f3 >= 3'd6));
    misal = (o % sz) != 0;
`ifdef LSU_MISALIGNED_SPLIT_EN
    err = illegal;
`else
    err = illegal || misal;
`endif
    rd = 32'h0;
    nwr = 0;
    if (err) begin
      lat = 1;
    end else if (!wr) begin
      for (int i = 0; i < sz; i++) rd = rd | ({24'h0, get_byte(addr + 32'(i))} << (8 * i));
      if (f3 == 3'd0 && rd[7])  rd = rd | 32'hFFFF_FF00;
      if (f3 == 3'd1 && rd[15]) rd = rd | 32'hFFFF_0000;
      lat = span ? 3 : 2;
    end else begin
      for (int i = 0; i < sz; i++) put_byte(addr + 32'(i), 8'(wd >> (8 * i)));
      lat = (f3 == 3'd2 && o == 0) ? 2 : (span ? 5 : 3);
      nwr = span ? 2 : 1;
    end
  endtask

  task automatic do_access(input string name, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    int          m_nwr;
    int          lat;
    int          nwr;
    bit          done;
    int          idx;
    model(wr, f3, addr, wd, m_rd, m_err, m_lat, m_nwr);
    @(negedge clock);
    check({name, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 1; nwr = 0; done = 1'b0;
    while (!done && lat <= 8) begin
      @(negedge clock);
      if (req_ready) check({name, " busy"}, 32'(req_ready), 32'd0);
      if (mem_addr[1:0] != 2'b00) check({name, " addr_align"}, {30'h0, mem_addr[1:0]}, 32'd0);
      if (!mem_we && mem_wdata != 32'h0) check({name, " wdata_idle"}, mem_wdata, 32'h0);
      if (rsp_valid) begin
        done = 1'b1;
        if (mem_addr != 32'h0) check({name, " resp_addr"}, mem_addr, 32'h0);
      end else begin
        if (mem_we) nwr++;
        @(posedge clock);
        lat++;
      end
    end
    check({name, " done"}, 32'(done), 32'd1);
    got_rd = rsp_rdata; got_err = rsp_err; got_lat = lat;
    check({name, " rdata"}, rsp_rdata, m_rd);
    check({name, " err"}, 32'(rsp_err), 32'(m_err));
    check({name, " latency"}, 32'(lat), 32'(m_lat));
    check({name, " writes"}, 32'(nwr), 32'(m_nwr));
    @(posedge clock);
    @(negedge clock);
    check({name, " oneshot"}, 32'(rsp_valid), 32'd0);
    check({name, " held"}, rsp_rdata, got_rd);
    idx = int'(addr[9:2]);
    check({name, " ram_lo"}, ram[idx], shadow[idx]);
    check({name, " ram_hi"}, ram[(idx + 1) % 256], shadow[(idx + 1) % 256]);
  endtask

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];

  initial begin
    logic [31:0] a_keep;
    logic [31:0] b_keep;
    logic [31:0] w0_keep;
    bit          seen_we;

    vecs.push_back('{"lw_al",    1'b0, 3'd2, 32'h40, 32'h0, 32'h4433_2211, 1'b0, 2});
    vecs.push_back('{"lbu_3",    1'b0, 3'd4, 32'h43, 32'h0, 32'h0000_0044, 1'b0, 2});
    vecs.push_back('{"lh_2",     1'b0, 3'd1, 32'h42, 32'h0, 32'h0000_4433, 1'b0, 2});
    vecs.push_back('{"lhu_0",    1'b0, 3'd5, 32'h40, 32'h0, 32'h0000_2211, 1'b0, 2});
    vecs.push_back('{"lb_neg",   1'b0, 3'd0, 32'h47, 32'h0, 32'hFFFF_FF88, 1'b0, 2});
    vecs.push_back('{"lh_neg",   1'b0, 3'd1, 32'h46, 32'h0, 32'hFFFF_8877, 1'b0, 2});
    vecs.push_back('{"ld_f3_3",  1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{"ld_f3_6",  1'b0, 3'd6, 32'h40, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{"st_f3_3",  1'b1, 3'd3, 32'h40, 32'h5, 32'h0, 1'b1, 1});
`ifdef LSU_MISALIGNED_SPLIT_EN
    vecs.push_back('{"lw_span",  1'b0, 3'd2, 32'h43, 32'h0, 32'h7766_5544, 1'b0, 3});
    vecs.push_back('{"lh_span",  1'b0, 3'd1, 32'h43, 32'h0, 32'h0000_5544, 1'b0, 3});
    vecs.push_back('{"sw_span",  1'b1, 3'd2, 32'h43, 32'hDEAD_BEEF, 32'h0, 1'b0, 5});
`else
    vecs.push_back('{"lw_mis",   1'b0, 3'd2, 32'h42, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{"lh_mis",   1'b0, 3'd1, 32'h43, 32'h0, 32'h0, 1'b1, 1});
    vecs.push_back('{"sh_mis",   1'b1, 3'd1, 32'h41, 32'h7, 32'h0, 1'b1, 1});
`endif
    vecs.push_back('{"sw_w0",    1'b1, 3'd2, 32'h00, 32'hCAFE_F00D, 32'h0, 1'b0, 2});

    #1;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rdata", rsp_rdata, 32'h0);
    check("rst err", 32'(rsp_err), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    for (int i = 0; i < 256; i++) preload(i, $urandom);
    @(negedge clock);
    reset = 1'b0;

    // Test plan: signed byte load then read-modify-write halfword store
    preload(16, 32'h8899_AABB);
    do_access("lb_41", 1'b0, 3'd0, 32'h41, 32'h0);
    check("lb_41 value", got_rd, 32'hFFFF_FFAA);
    check("lb_41 lat", 32'(got_lat), 32'd2);
    do_access("sh_42", 1'b1, 3'd1, 32'h42, 32'h1234);
    check("sh_42 word", ram[16], 32'h1234_AABB);
    check("sh_42 lat", 32'(got_lat), 32'd3);

    preload(16, 32'h4433_2211);
    preload(17, 32'h8877_6655);
    w0_keep = ram[0];
    foreach (vecs[i]) begin
      do_access(vecs[i].name, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd);
      check({vecs[i].name, " vec_rd"}, got_rd, vecs[i].exp_rd);
      check({vecs[i].name, " vec_err"}, 32'(got_err), 32'(vecs[i].exp_err));
      check({vecs[i].name, " vec_lat"}, 32'(got_lat), 32'(vecs[i].exp_lat));
    end
    check("sw_w0 unchanged", ram[0], w0_keep);
`ifdef LSU_MISALIGNED_SPLIT_EN
    check("sw_span lo", ram[16], 32'hEF33_2211);
    check("sw_span hi", ram[17], 32'h88DE_ADBE);
`else
    check("mis lo", ram[16], 32'h4433_2211);
`endif

    // Reset while the (first) write strobe is up must cancel the rest of the access
    a_keep = ram[32];
    b_keep = ram[33];
    @(negedge clock);
    req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h5A5A_A5A5;
`ifdef LSU_MISALIGNED_SPLIT_EN
    req_funct3 = 3'd2; req_addr = 32'h83;
`else
    req_funct3 = 3'd0; req_addr = 32'h80;
`endif
    @(posedge clock);
    #1 req_valid = 1'b0;
    seen_we = 1'b0;
    for (int c = 0; c < 8 && !seen_we; c++) begin
      @(negedge clock);
      if (mem_we) seen_we = 1'b1;
    end
    check("rst_mid reached_wr", 32'(seen_we), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid ready", 32'(req_ready), 32'd1);
    check("rst_mid mem_we", 32'(mem_we), 32'd0);
    check("rst_mid mem_addr", mem_addr, 32'h0);
    check("rst_mid mem_wdata", mem_wdata, 32'h0);
    check("rst_mid rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid rdata", rsp_rdata, 32'h0);
    check("rst_mid err", 32'(rsp_err), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      check("rst_hold mem_we", 32'(mem_we), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    check("rst_rel ready", 32'(req_ready), 32'd1);
    check("rst_mid word lo", ram[32], a_keep);
    check("rst_mid word hi", ram[33], b_keep);

    // Random accesses against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra;
      ra = 32'($urandom_range(32'h8, 32'h3F0));
      if (n % 16 == 0) ra = 32'($urandom_range(32'h0, 32'h7));
      do_access("rand", 1'($urandom), 3'($urandom), ra, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
